// File: rtl/bp_btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters.
// Valid bits are cleared one set per cycle by an init/flush sequencer.
module bp_btb_assoc #(
    parameter int SETS     = 256,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2,
    parameter int PC_W     = 30,
    parameter int TGT_W    = 30
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    output logic             ready,
    input  logic [PC_W-1:0]  pc_f,
    output logic             hit_f,
    output logic             taken_f,
    output logic [TGT_W-1:0] target_f,
    input  logic             upd_en,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [TGT_W-1:0] upd_target
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(2 ** (CTR_BITS - 1));

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [IDX-1:0]  init_idx;

    logic                vld   [SETS][WAYS];
    logic [TAG_W-1:0]    tag_a [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr_a [SETS][WAYS];
    logic [TGT_W-1:0]    tgt_a [SETS][WAYS];
    logic                lru   [SETS];

    logic [IDX-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit, u_way, victim, run;

    assign f_idx = pc_f[IDX-1:0];
    assign f_tag = pc_f[PC_W-1:IDX];
    assign u_idx = upd_pc[IDX-1:0];
    assign u_tag = upd_pc[PC_W-1:IDX];
    assign run   = rstn && (state == RUN);
    assign ready = run;

    // Sequencer: walk every set while in INIT, then serve lookups in RUN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == IDX'(SETS - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (flush) begin
                        state    <= INIT;
                        init_idx <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Fetch lookup: descending scan so the lowest matching way wins
    always_comb begin
        hit_f    = 1'b0;
        taken_f  = 1'b0;
        target_f = '0;
        if (run) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (vld[f_idx][w] && tag_a[f_idx][w] == f_tag) begin
                    hit_f    = 1'b1;
                    taken_f  = ctr_a[f_idx][w][CTR_BITS-1];
                    target_f = tgt_a[f_idx][w];
                end
            end
        end
    end

    // Update-side match and victim choice (first invalid way, else LRU)
    always_comb begin
        u_hit  = 1'b0;
        u_way  = 1'b0;
        victim = (WAYS == 1) ? 1'b0 : lru[u_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld[u_idx][w] && tag_a[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = 1'(w);
            end
            if (!vld[u_idx][w])
                victim = 1'(w);
        end
    end

    // Array writes: per-set clear in INIT, counter/target update in RUN
    always_ff @(posedge clk) begin
        if (rstn && state == INIT) begin
            for (int w = 0; w < WAYS; w++)
                vld[init_idx][w] <= 1'b0;
            lru[init_idx] <= 1'b0;
        end else if (run && upd_en && !flush) begin
            for (int w = 0; w < WAYS; w++) begin
                if (u_hit && u_way == 1'(w)) begin
                    if (upd_taken) begin
                        if (ctr_a[u_idx][w] != CTR_MAX)
                            ctr_a[u_idx][w] <= ctr_a[u_idx][w] + 1'b1;
                        tgt_a[u_idx][w] <= upd_target;
                    end else if (ctr_a[u_idx][w] != '0) begin
                        ctr_a[u_idx][w] <= ctr_a[u_idx][w] - 1'b1;
                    end
                end else if (!u_hit && upd_taken && victim == 1'(w)) begin
                    vld[u_idx][w]   <= 1'b1;
                    tag_a[u_idx][w] <= u_tag;
                    ctr_a[u_idx][w] <= CTR_WEAK;
                    tgt_a[u_idx][w] <= upd_target;
                end
            end
            if (u_hit)
                lru[u_idx] <= ~u_way;
            else if (upd_taken)
                lru[u_idx] <= ~victim;
        end
    end

endmodule

// File: tb/tb_bp_btb_assoc.sv
// Directed bench for bp_btb_assoc with a lookup scoreboard queue.
// Expected lookup results are queued as stimulus is applied, then checked.
module tb_bp_btb_assoc;

    logic        clk = 1'b0;
    logic        rstn, flush, ready;
    logic [29:0] pc_f;
    logic        hit_f, taken_f;
    logic [29:0] target_f;
    logic        upd_en, upd_taken;
    logic [29:0] upd_pc, upd_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hit;
        logic        tk;
        logic [29:0] tgt;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    bp_btb_assoc dut (
        .clk(clk), .rstn(rstn), .flush(flush), .ready(ready),
        .pc_f(pc_f), .hit_f(hit_f), .taken_f(taken_f),
        .target_f(target_f), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
        end
    endtask

    // Drive a lookup, queue its expectation, then pop and compare
    task automatic look(input string nm, input logic [29:0] pc,
                        input logic h, input logic t,
                        input logic [29:0] tg);
        exp_t e;
        string n;
        pc_f = pc;
        exp_q.push_back('{hit: h, tk: t, tgt: tg});
        nm_q.push_back(nm);
        #1;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        checks++;
        assert ({hit_f, taken_f, target_f} === {e.hit, e.tk, e.tgt}) else begin
            errors++;
            $error("FAIL %s observed=%b/%b/%h expected=%b/%b/%h", n,
                   hit_f, taken_f, target_f, e.hit, e.tk, e.tgt);
        end
    endtask

    task automatic upd(input logic [29:0] pc, input logic tk,
                       input logic [29:0] tg);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        step();
        upd_en = 1'b0;
    endtask

    task automatic wait_init(input string nm, input logic [29:0] probe);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            if (n == 5)
                look({nm, "_lookup"}, probe, 1'b0, 1'b0, 30'h0);
            n++;
            step();
        end
        chk({nm, "_len"}, n, 256);
    endtask

    localparam logic [29:0] P1 = 30'h0000104;
    localparam logic [29:0] PA = 30'h100;
    localparam logic [29:0] PB = 30'h200;
    localparam logic [29:0] PC = 30'h300;
    localparam logic [29:0] PX = 30'h404;
    localparam logic [29:0] PY = 30'h508;

    initial begin
        rstn = 1'b0; flush = 1'b0; pc_f = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        @(negedge clk);
        step(); step();
        chk("reset_ready", int'(ready), 0);
        look("reset_lookup", P1, 1'b0, 1'b0, 30'h0);

        rstn = 1'b1;
        wait_init("init", P1);
        chk("run_ready", int'(ready), 1);

        upd(P1, 1'b1, 30'h200);
        look("alloc_hit", P1, 1'b1, 1'b1, 30'h200);
        upd(30'h108, 1'b0, 30'h77);
        look("nt_no_alloc", 30'h108, 1'b0, 1'b0, 30'h0);

        upd(P1, 1'b1, 30'h200);
        upd(P1, 1'b1, 30'h200);
        upd(P1, 1'b1, 30'h200);
        look("sat_top", P1, 1'b1, 1'b1, 30'h200);
        upd(P1, 1'b0, 30'h3ff);
        look("dec_to_2", P1, 1'b1, 1'b1, 30'h200);
        upd(P1, 1'b0, 30'h3ff);
        look("dec_to_1", P1, 1'b1, 1'b0, 30'h200);
        upd(P1, 1'b0, 30'h3ff);
        upd(P1, 1'b0, 30'h3ff);
        look("dec_to_0", P1, 1'b1, 1'b0, 30'h200);
        upd(P1, 1'b0, 30'h3ff);
        look("sat_bottom", P1, 1'b1, 1'b0, 30'h200);
        upd(P1, 1'b1, 30'h321);
        look("inc_to_1", P1, 1'b1, 1'b0, 30'h321);
        upd(P1, 1'b1, 30'h321);
        look("inc_to_2", P1, 1'b1, 1'b1, 30'h321);

        upd(PA, 1'b1, 30'h0a);
        upd(PB, 1'b1, 30'h0b);
        upd(PA, 1'b1, 30'h0a);
        upd(PC, 1'b1, 30'h0c);
        look("assoc_a", PA, 1'b1, 1'b1, 30'h0a);
        look("assoc_c", PC, 1'b1, 1'b1, 30'h0c);
        look("assoc_b_evicted", PB, 1'b0, 1'b0, 30'h0);

        upd_en = 1'b1; upd_pc = PX; upd_taken = 1'b1; upd_target = 30'h44;
        look("hazard_same", PX, 1'b0, 1'b0, 30'h0);
        step();
        upd_en = 1'b0;
        look("hazard_next", PX, 1'b1, 1'b1, 30'h44);

        flush = 1'b1;
        upd_en = 1'b1; upd_pc = PY; upd_taken = 1'b1; upd_target = 30'h11;
        step();
        flush = 1'b0;
        upd_en = 1'b0;
        chk("flush_ready", int'(ready), 0);
        wait_init("flush", PA);
        look("flush_a", PA, 1'b0, 1'b0, 30'h0);
        look("flush_c", PC, 1'b0, 1'b0, 30'h0);
        look("flush_p1", P1, 1'b0, 1'b0, 30'h0);
        look("flush_x", PX, 1'b0, 1'b0, 30'h0);
        look("flush_dropped", PY, 1'b0, 1'b0, 30'h0);

        upd(PY, 1'b1, 30'h12);
        look("post_flush_alloc", PY, 1'b1, 1'b1, 30'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_btb_assoc.md
Name: bp_btb_assoc

Overview:
- Parametrised successor to the direct-mapped branch history buffer: a set-associative branch target buffer with N-bit saturating direction counters and stored branch targets.
- Fetch stage does a same-cycle lookup on the fetch PC and gets hit, taken and target.
- Execute stage writes resolved branch outcomes.
- Includes an init/flush sequencer that clears valid bits one set per cycle, so the array maps to RAM without a bulk reset.

Parameters:
- SETS, 256, number of sets; power of two, at least 2.
- WAYS, 2, associativity; 1 or 2.
- CTR_BITS, 2, saturating counter width; 1 to 4.
- PC_W, 30, word-address PC width (byte PC[31:2]).
- TGT_W, 30, stored target width (word address).

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rstn, input, 1, synchronous active-low reset.
- flush, input, 1, pulse; invalidates all entries through the INIT sequence.
- ready, output, 1, high when the array is usable; low during INIT.
- pc_f, input, PC_W, fetch-stage word PC.
- hit_f, output, 1, valid entry with a matching tag exists for pc_f.
- taken_f, output, 1, predicted taken; counter MSB of the hit way, otherwise 0.
- target_f, output, TGT_W, stored target of the hit way, otherwise 0.
- upd_en, input, 1, a branch resolved in EX this cycle.
- upd_pc, input, PC_W, PC of the resolved branch.
- upd_taken, input, 1, actual outcome.
- upd_target, input, TGT_W, actual computed target.

Behaviour:
- Address split: IDX = log2(SETS). Index = pc[IDX-1:0]; tag = pc[PC_W-1:IDX].
- Entry fields: valid, tag, ctr[CTR_BITS-1:0], target. Each set also holds one LRU bit, which is unused when WAYS=1.
- Reset: while rstn=0, state=INIT, init_idx=0, ready=0, hit_f=0, taken_f=0, target_f=0.
- FSM has two states, INIT and RUN.
  - INIT: each cycle clears the valid bits and LRU of set init_idx, then increments init_idx. After set SETS-1 is cleared, go to RUN on the next edge. INIT therefore lasts exactly SETS cycles after reset release.
  - In INIT, upd_en is ignored and the lookup outputs are forced to 0.
  - RUN: ready=1. A flush moves the FSM to INIT with init_idx=0 on the next edge, and upd_en in that same cycle is dropped.
- Lookup is combinational with zero latency. It reads the array state as of the last edge, so an update in the same cycle is not visible until the next cycle.
- If more than one way matches (not legal, but must be handled), the lowest way wins.
- Update (RUN, upd_en=1), applied at the edge:
  - Hit in way w: ctr saturating increment if upd_taken, else saturating decrement. Limits are 0 and 2^CTR_BITS-1, and values never wrap. target <= upd_target only when upd_taken. LRU <= the other way.
  - Miss with upd_taken=1: allocate. The victim is the first invalid way; if all ways are valid, the LRU way. Write valid=1, tag, ctr = 2^(CTR_BITS-1) (weakly taken), target = upd_target. LRU <= the other way.
  - Miss with upd_taken=0: no write, because not-taken branches are not allocated.
- Lookup does not touch LRU.
- Simultaneous lookup and update to the same set: lookup returns the pre-update contents.
- A reset asserted mid-INIT or mid-RUN restarts INIT from set 0.

Test Plan:
- Reset release (SETS=256): ready=0 for 256 cycles, then 1. During INIT, pc_f=any gives hit_f=0 and taken_f=0.
- Allocate: update pc=0x0000104, taken, target=0x0000200. Next cycle pc_f=0x0000104 gives hit_f=1, taken_f=1, target_f=0x0000200. A not-taken update to the fresh pc 0x0000108 leaves hit_f=0.
- Saturation (CTR_BITS=2): starting from ctr=2, 3 taken updates give ctr=3 with taken_f=1. Then 2 not-taken give ctr=1 and taken_f=0. 3 more not-taken give ctr=0, which holds with no wrap. target_f stays 0x0000200 through all not-taken updates.
- Associativity (WAYS=2, SETS=256): taken updates A=0x100, B=0x200, C=0x300 all map to set 0. Before C, touch A with one more update. After C, A hits, C hits, and B misses (B was the LRU victim).
- Same-cycle hazard: upd_en allocates pc X while pc_f=X. In that cycle hit_f=0; the next cycle hit_f=1.
- Flush: in RUN with entries valid, pulse flush together with upd_en. ready drops the next cycle for 256 cycles. Afterwards all lookups miss and the dropped update is absent.
